// File: rtl/pool_binarizer_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared types and constants for the pooling/binarization stage.
//   pool_mode_e   : pooling mode carried on the mode input (2'b11 is reserved
//                   and treated as bypass by the datapath).
//   res_state_e   : result slot state (EMPTY = no result, FULL = result held).
//   BIN_*         : per-lane code values.
//   pool_result_t : wide result container sized for the largest legal window.
//   bin_code()    : maps (lane filled, lane above threshold) to a lane code.
// -----------------------------------------------------------------------------
package pool_pkg;

  typedef enum logic [1:0] {
    POOL_BYPASS = 2'b00,
    POOL_MAX    = 2'b01,
    POOL_SUM    = 2'b10
  } pool_mode_e;

  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  localparam logic [7:0] BIN_POS  = 8'h01;
  localparam logic [7:0] BIN_NEG  = 8'hFF;
  localparam logic [7:0] BIN_NONE = 8'h00;

  localparam int MAX_WIN    = 16;
  localparam int MAX_POOL_W = 32;
  localparam int MAX_CNT_W  = 5;

  typedef struct packed {
    logic [MAX_WIN-1:0][7:0] bits;
    logic [MAX_POOL_W-1:0]   pool;
    logic                    pool_bit;
    logic [MAX_CNT_W-1:0]    count;
  } pool_result_t;

  // Unfilled lanes read as "no value"; filled lanes are +1 / -1 codes.
  function automatic logic [7:0] bin_code(input logic filled, input logic above);
    logic [7:0] code;
    if (!filled) begin
      code = BIN_NONE;
    end else if (above) begin
      code = BIN_POS;
    end else begin
      code = BIN_NEG;
    end
    return code;
  endfunction

endpackage

// File: rtl/pool_binarizer_if.sv
// -----------------------------------------------------------------------------
// pool_binarizer_if
// Stream bundle for pool_binarizer.
//   Upstream : in_valid / in_ready / in_data, plus flush, mode, threshold.
//   Result   : out_valid / out_ready, out_bits (lane 0 = oldest sample),
//              out_pool, out_pool_bit, out_count.
//   master   : the side that feeds samples and consumes results.
//   slave    : the pooling stage itself.
// -----------------------------------------------------------------------------
interface pool_binarizer_if #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int POOL_W = DATA_W + $clog2(WIN)
);
  localparam int CNT_W = $clog2(WIN + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    flush;
  logic [1:0]              mode;
  logic [DATA_W-1:0]       threshold;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIN-1:0][7:0]     out_bits;
  logic [POOL_W-1:0]       out_pool;
  logic                    out_pool_bit;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_data, flush, mode, threshold, out_ready,
    input  in_ready, out_valid, out_bits, out_pool, out_pool_bit, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, mode, threshold, out_ready,
    output in_ready, out_valid, out_bits, out_pool, out_pool_bit, out_count
  );

endinterface

// File: rtl/pool_binarizer_reduce.sv
// -----------------------------------------------------------------------------
// pool_reduce
// Combinational signed max and sum over a lane vector with a lane-valid mask.
//   i_lanes : WIN lanes of DATA_W-bit signed samples
//   i_mask  : lane-valid mask (1 = lane participates)
//   o_max   : signed maximum; masked lanes contribute the most negative value
//   o_sum   : signed sum; masked lanes contribute 0. SUM_W cannot overflow.
// -----------------------------------------------------------------------------
module pool_reduce #(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int SUM_W  = DATA_W + $clog2(WIN)
) (
  input  logic [WIN-1:0][DATA_W-1:0] i_lanes,
  input  logic [WIN-1:0]             i_mask,
  output logic signed [DATA_W-1:0]   o_max,
  output logic signed [SUM_W-1:0]    o_sum
);

  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [DATA_W-1:0] w_max_in [WIN];
  logic signed [SUM_W-1:0]  w_sum_in [WIN];

  for (genvar g = 0; g < WIN; g++) begin : g_lane
    assign w_max_in[g] = i_mask[g] ? $signed(i_lanes[g]) : MIN_VAL;
    assign w_sum_in[g] = i_mask[g] ? SUM_W'($signed(i_lanes[g])) : {SUM_W{1'b0}};
  end

  // Running max / sum across the lanes.
  always_comb begin
    o_max = MIN_VAL;
    o_sum = {SUM_W{1'b0}};
    for (int i = 0; i < WIN; i++) begin
      if (w_max_in[i] > o_max) begin
        o_max = w_max_in[i];
      end else begin
        o_max = o_max;
      end
      o_sum = o_sum + w_sum_in[i];
    end
  end

endmodule

// File: rtl/pool_binarizer.sv
// -----------------------------------------------------------------------------
// pool_binarizer
// Streaming window pooling + binarization stage.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (discards any partial window)
//   bus   : pool_binarizer_if.slave stream bundle
// Samples fill lanes 0..WIN-1 of a window; a full window (or a flushed partial
// one) is registered as one result: per-lane +/-1 codes, pooled value and its
// binarized bit. mode/threshold are captured with lane 0 of each window.
// -----------------------------------------------------------------------------
module pool_binarizer
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WIN    = 4,
  parameter int POOL_W = DATA_W + $clog2(WIN)
) (
  input  logic          clk,
  input  logic          rst_n,
  pool_binarizer_if.slave bus
);

  localparam int CNT_W = $clog2(WIN + 1);
  localparam int SUM_W = DATA_W + $clog2(WIN);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST_LANE = cnt_t'(WIN - 1);

  logic [WIN-1:0][DATA_W-1:0] r_lane, w_lane_nx;
  cnt_t                       r_fill, w_cnt_nx;
  logic [1:0]                 r_mode, w_mode_use;
  logic [DATA_W-1:0]          r_thr, w_thr_use;
  logic                       r_flush_pend;
  res_state_e                 r_state, w_state_nx;
  logic [WIN-1:0][7:0]        r_bits, w_bits;
  logic [POOL_W-1:0]          r_pool, w_pool;
  logic                       r_pool_bit, w_pool_bit;
  cnt_t                       r_count;

  logic                       w_slot_free, w_acc, w_first, w_complete;
  logic                       w_emit_flush, w_emit, w_set_pend;
  logic [WIN-1:0]             w_mask;
  logic signed [DATA_W-1:0]   w_max;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [POOL_W-1:0]   w_max_ext, w_sum_ext, w_thr_ext;

  assign w_slot_free  = (r_state == RES_EMPTY) || bus.out_ready;
  assign bus.in_ready = rst_n && w_slot_free;
  assign w_acc        = bus.in_valid && bus.in_ready;
  assign w_first      = (r_fill == cnt_t'(0));
  assign w_complete   = w_acc && (r_fill == LAST_LANE);
  assign w_cnt_nx     = r_fill + cnt_t'(w_acc);

  // A flush closes whatever the window holds after this cycle's sample; a
  // completing sample already closes it, so flush adds nothing then.
  assign w_emit_flush = (bus.flush || r_flush_pend) && w_slot_free &&
                        (w_cnt_nx != cnt_t'(0)) && !w_complete;
  assign w_emit       = w_complete || w_emit_flush;
  assign w_set_pend   = bus.flush && !w_slot_free && (r_fill != cnt_t'(0));

  // The window being closed may have its lane 0 arriving right now, in which
  // case the live mode/threshold apply rather than the stale latched copy.
  assign w_mode_use = w_first ? bus.mode      : r_mode;
  assign w_thr_use  = w_first ? bus.threshold : r_thr;

  // Lane vector including this cycle's accepted sample, plus fill mask.
  always_comb begin
    w_lane_nx = r_lane;
    w_mask    = {WIN{1'b0}};
    for (int i = 0; i < WIN; i++) begin
      if (w_acc && (r_fill == cnt_t'(i))) begin
        w_lane_nx[i] = bus.in_data;
      end else begin
        w_lane_nx[i] = r_lane[i];
      end
      w_mask[i] = (cnt_t'(i) < w_cnt_nx);
    end
  end

  pool_reduce #(
    .DATA_W (DATA_W),
    .WIN    (WIN),
    .SUM_W  (SUM_W)
  ) u_reduce (
    .i_lanes (w_lane_nx),
    .i_mask  (w_mask),
    .o_max   (w_max),
    .o_sum   (w_sum)
  );

  assign w_max_ext = POOL_W'(w_max);
  assign w_sum_ext = POOL_W'(w_sum);
  assign w_thr_ext = POOL_W'($signed(w_thr_use));

  // Per-lane +/-1 codes against the window's threshold.
  always_comb begin
    w_bits = {WIN{BIN_NONE}};
    for (int i = 0; i < WIN; i++) begin
      w_bits[i] = bin_code(w_mask[i], $signed(w_lane_nx[i]) > $signed(w_thr_use));
    end
  end

  // Pooled value and its binarized bit; reserved mode behaves as bypass.
  always_comb begin
    w_pool     = {POOL_W{1'b0}};
    w_pool_bit = 1'b0;
    case (w_mode_use)
      POOL_MAX: begin
        w_pool     = w_max_ext;
        w_pool_bit = (w_max_ext > w_thr_ext);
      end
      POOL_SUM: begin
        w_pool     = w_sum_ext;
        w_pool_bit = (w_sum_ext > w_thr_ext);
      end
      default: begin
        w_pool     = {POOL_W{1'b0}};
        w_pool_bit = 1'b0;
      end
    endcase
  end

  // Result slot next state: a new result always lands in FULL, even while
  // the previous one is being drained.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      RES_EMPTY: begin
        if (w_emit) begin
          w_state_nx = RES_FULL;
        end else begin
          w_state_nx = RES_EMPTY;
        end
      end
      RES_FULL: begin
        if (w_emit) begin
          w_state_nx = RES_FULL;
        end else if (bus.out_ready) begin
          w_state_nx = RES_EMPTY;
        end else begin
          w_state_nx = RES_FULL;
        end
      end
      default: begin
        w_state_nx = RES_EMPTY;
      end
    endcase
  end

  // Result slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RES_EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Lane buffer, fill counter, window settings, flush-pending and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane       <= '0;
      r_fill       <= cnt_t'(0);
      r_mode       <= 2'b00;
      r_thr        <= {DATA_W{1'b0}};
      r_flush_pend <= 1'b0;
      r_bits       <= {WIN{BIN_NONE}};
      r_pool       <= {POOL_W{1'b0}};
      r_pool_bit   <= 1'b0;
      r_count      <= cnt_t'(0);
    end else begin
      if (w_acc) begin
        r_lane <= w_lane_nx;
      end
      if (w_acc && w_first) begin
        r_mode <= bus.mode;
        r_thr  <= bus.threshold;
      end
      if (w_emit) begin
        r_bits     <= w_bits;
        r_pool     <= w_pool;
        r_pool_bit <= w_pool_bit;
        r_count    <= w_cnt_nx;
        r_fill     <= cnt_t'(0);
      end else if (w_acc) begin
        r_fill <= w_cnt_nx;
      end
      if (w_emit) begin
        r_flush_pend <= 1'b0;
      end else if (w_set_pend) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

  assign bus.out_valid    = (r_state == RES_FULL);
  assign bus.out_bits     = r_bits;
  assign bus.out_pool     = r_pool;
  assign bus.out_pool_bit = r_pool_bit;
  assign bus.out_count    = r_count;

endmodule
